fetch_branch_requester: RTL and testbench

- Instruction-fetch-side initiator for the 2-bit branch predictor. It owns the PC and accepts instructions from the icache.
- For each conditional branch it computes the taken target and the fall-through address, issues a one-cycle ask to the predictor, waits for the answer, and redirects the PC.
- It applies predictor flushes, which carry the recovery PC, and JALR redirects from the ROB.
- It sits between the icache and the decoder.

---
 rtl/riscv_defs.sv | 18 +
 rtl/fetch_branch_requester_if.sv | 50 +++++
 rtl/ctrl_imm_decode.sv | 33 +++
 rtl/fetch_branch_requester.sv | 132 +++++++++++++
 tb/tb_fetch_branch_requester.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_defs.sv
// Shared RISC-V fetch definitions: opcodes, instruction width and the fetch FSM states.
package riscv_defs;

  localparam int INS_WIDTH = 32;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASK,
    ST_WAIT,
    ST_JALR_STALL,
    ST_FLUSH_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_branch_requester_if.sv
// Fetch-side bundle: icache input, decoder output, predictor query/answer and ROB redirect.
interface fetch_branch_requester_if
  import riscv_defs::*;
#(
  parameter int ADDR_WIDTH = 32
);
  logic                  rdy;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_valid;
  logic                  ins_valid;
  logic [INS_WIDTH-1:0]  ins;
  logic [ADDR_WIDTH-1:0] ins_addr;
  logic                  dispatch_full;
  logic [INS_WIDTH-1:0]  ins_out;
  logic [ADDR_WIDTH-1:0] ins_out_addr;
  logic                  ins_out_valid;
  logic                  ins_out_pred_jump;
  logic                  ask_predictor;
  logic [ADDR_WIDTH-1:0] now_ins_addr;
  logic [ADDR_WIDTH-1:0] jump_addr_to_predictor;
  logic [ADDR_WIDTH-1:0] next_addr_to_predictor;
  logic                  jump;
  logic                  predictor_sgn_rdy;
  logic                  predictor_full;
  logic                  if_flush;
  logic [ADDR_WIDTH-1:0] addr_from_predictor;
  logic                  jalr_resolve_valid;
  logic [ADDR_WIDTH-1:0] jalr_target;

  modport master (
    input  rdy,
    output pc, pc_valid,
    input  ins_valid, ins, ins_addr, dispatch_full,
    output ins_out, ins_out_addr, ins_out_valid, ins_out_pred_jump,
    output ask_predictor, now_ins_addr, jump_addr_to_predictor, next_addr_to_predictor,
    input  jump, predictor_sgn_rdy, predictor_full, if_flush, addr_from_predictor,
    input  jalr_resolve_valid, jalr_target
  );

  modport slave (
    output rdy,
    input  pc, pc_valid,
    output ins_valid, ins, ins_addr, dispatch_full,
    input  ins_out, ins_out_addr, ins_out_valid, ins_out_pred_jump,
    input  ask_predictor, now_ins_addr, jump_addr_to_predictor, next_addr_to_predictor,
    output jump, predictor_sgn_rdy, predictor_full, if_flush, addr_from_predictor,
    output jalr_resolve_valid, jalr_target
  );

endinterface

// File: rtl/ctrl_imm_decode.sv
// Combinational control-flow decode: classifies the instruction and forms branch/JAL offsets.
module ctrl_imm_decode
  import riscv_defs::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [INS_WIDTH-1:0]  ins,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  is_branch,
  output logic                  is_jal,
  output logic                  is_jalr,
  output logic [ADDR_WIDTH-1:0] imm_j,
  output logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] fall_through
);
  logic [12:0]           raw_b;
  logic [20:0]           raw_j;
  logic [ADDR_WIDTH-1:0] imm_b;

  assign is_branch = (ins[6:0] == OPC_BRANCH);
  assign is_jal    = (ins[6:0] == OPC_JAL);
  assign is_jalr   = (ins[6:0] == OPC_JALR);

  // Immediate bits are scattered across the word; reassemble then sign-extend.
  assign raw_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign raw_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_b = {{(ADDR_WIDTH-13){raw_b[12]}}, raw_b};
  assign imm_j = {{(ADDR_WIDTH-21){raw_j[20]}}, raw_j};

  assign branch_target = addr + imm_b;
  assign fall_through  = addr + ADDR_WIDTH'(4);

endmodule

// File: rtl/fetch_branch_requester.sv
// Fetch unit that owns the PC, forwards instructions to decode and consults the branch
// predictor for every conditional branch before redirecting.
module fetch_branch_requester
  import riscv_defs::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  fetch_branch_requester_if.master bus
);
  fetch_state_t          state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [INS_WIDTH-1:0]  br_ins_reg;
  logic [ADDR_WIDTH-1:0] br_addr_reg;
  logic [ADDR_WIDTH-1:0] br_jump_reg;
  logic [ADDR_WIDTH-1:0] br_next_reg;
  logic                  out_valid_reg;
  logic                  out_pred_jump_reg;
  logic [INS_WIDTH-1:0]  out_ins_reg;
  logic [ADDR_WIDTH-1:0] out_addr_reg;

  logic                  dec_is_branch;
  logic                  dec_is_jal;
  logic                  dec_is_jalr;
  logic [ADDR_WIDTH-1:0] dec_imm_j;
  logic [ADDR_WIDTH-1:0] dec_target;
  logic [ADDR_WIDTH-1:0] dec_fall;
  logic                  accept;
  logic                  ask;

  ctrl_imm_decode #(.ADDR_WIDTH(ADDR_WIDTH)) u_decode (
    .ins           (bus.ins),
    .addr          (bus.ins_addr),
    .is_branch     (dec_is_branch),
    .is_jal        (dec_is_jal),
    .is_jalr       (dec_is_jalr),
    .imm_j         (dec_imm_j),
    .branch_target (dec_target),
    .fall_through  (dec_fall)
  );

  assign accept = bus.ins_valid && (bus.ins_addr == pc_reg) && !bus.dispatch_full;
  // The predictor must never see a query while it is full or being flushed.
  assign ask    = (state_reg == ST_ASK) && bus.rdy && !bus.predictor_full
                  && !bus.if_flush && !rst;

  assign bus.pc                     = pc_reg;
  assign bus.pc_valid               = (state_reg == ST_IDLE) && !rst;
  assign bus.ask_predictor          = ask;
  assign bus.now_ins_addr           = br_addr_reg;
  assign bus.jump_addr_to_predictor = br_jump_reg;
  assign bus.next_addr_to_predictor = br_next_reg;
  assign bus.ins_out                = out_ins_reg;
  assign bus.ins_out_addr           = out_addr_reg;
  assign bus.ins_out_valid          = out_valid_reg;
  assign bus.ins_out_pred_jump      = out_pred_jump_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      pc_reg            <= RESET_PC;
      br_ins_reg        <= '0;
      br_addr_reg       <= '0;
      br_jump_reg       <= '0;
      br_next_reg       <= '0;
      out_valid_reg     <= 1'b0;
      out_pred_jump_reg <= 1'b0;
      out_ins_reg       <= '0;
      out_addr_reg      <= '0;
    end else if (bus.rdy) begin
      out_valid_reg <= 1'b0;
      if (bus.if_flush) begin
        pc_reg      <= bus.addr_from_predictor;
        state_reg   <= ST_FLUSH_HOLD;
        br_ins_reg  <= '0;
        br_addr_reg <= '0;
        br_jump_reg <= '0;
        br_next_reg <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (accept) begin
              if (dec_is_branch) begin
                br_ins_reg  <= bus.ins;
                br_addr_reg <= bus.ins_addr;
                br_jump_reg <= dec_target;
                br_next_reg <= dec_fall;
                state_reg   <= ST_ASK;
              end else begin
                out_valid_reg     <= 1'b1;
                out_pred_jump_reg <= 1'b0;
                out_ins_reg       <= bus.ins;
                out_addr_reg      <= bus.ins_addr;
                if (dec_is_jal) begin
                  pc_reg <= bus.ins_addr + dec_imm_j;
                end else if (dec_is_jalr) begin
                  state_reg <= ST_JALR_STALL;
                end else begin
                  pc_reg <= dec_fall;
                end
              end
            end
          end
          ST_ASK: begin
            if (ask) state_reg <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.predictor_sgn_rdy) begin
              out_valid_reg     <= 1'b1;
              out_pred_jump_reg <= bus.jump;
              out_ins_reg       <= br_ins_reg;
              out_addr_reg      <= br_addr_reg;
              pc_reg            <= bus.jump ? br_jump_reg : br_next_reg;
              state_reg         <= ST_IDLE;
            end
          end
          ST_JALR_STALL: begin
            if (bus.jalr_resolve_valid) begin
              pc_reg    <= bus.jalr_target;
              state_reg <= ST_IDLE;
            end
          end
          ST_FLUSH_HOLD: state_reg <= ST_IDLE;
          default:       state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_branch_requester.sv
// Bench for fetch_branch_requester: directed vector table, hand sequences, then random traffic
// checked against a flag-based reference model of the fetch/predict protocol.
module tb_fetch_branch_requester;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_branch_requester_if #(.ADDR_WIDTH(32)) bus ();

  fetch_branch_requester #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    logic [31:0] ins_addr;
    logic [31:0] ins;
    logic        dfull;
    logic        exp_valid;
    logic        exp_pc_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  // reference model state
  logic [31:0] m_pc;
  bit          m_br_pending, m_br_asked, m_jalr, m_hold;
  logic [31:0] m_br_addr, m_br_ins;
  int          m_br_off;
  bit          m_out_valid, m_out_pj;
  logic [31:0] m_out_ins, m_out_addr;
  int          r_kind, r_off;

  function automatic logic [31:0] enc_b(input int off, input logic [2:0] f3);
    logic [12:0] o;
    o = off[12:0];
    return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] o;
    o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr();
    return {12'h010, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_add();
    return {7'b0, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi();
    return {12'h123, 5'd2, 3'b000, 5'd1, 7'b0010011};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] sp, input logic [31:0] ia,
                              input logic [31:0] i, input logic df, input logic ev,
                              input logic epv, input logic [31:0] ep);
    vec_t v;
    v.name = n; v.start_pc = sp; v.ins_addr = ia; v.ins = i; v.dfull = df;
    v.exp_valid = ev; v.exp_pc_valid = epv; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rdy = 1'b1; bus.ins_valid = 1'b0; bus.ins = '0; bus.ins_addr = '0;
    bus.dispatch_full = 1'b0; bus.jump = 1'b0; bus.predictor_sgn_rdy = 1'b0;
    bus.predictor_full = 1'b0; bus.if_flush = 1'b0; bus.addr_from_predictor = '0;
    bus.jalr_resolve_valid = 1'b0; bus.jalr_target = '0;
  endtask

  // Redirect via a predictor flush, step through the one-cycle hold, land in fetch.
  task automatic goto_pc(input logic [31:0] a);
    bus.if_flush = 1'b1; bus.addr_from_predictor = a;
    tick();
    bus.if_flush = 1'b0;
    #1;
    chk("flush_pc", bus.pc, a);
    chk("hold_pc_valid", bus.pc_valid, 1'b0);
    chk("hold_ask", bus.ask_predictor, 1'b0);
    tick();
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] i);
    bus.ins_valid = 1'b1; bus.ins_addr = a; bus.ins = i;
    tick();
    bus.ins_valid = 1'b0;
  endtask

  task automatic branch_seq(input logic j, input logic [31:0] exp_pc);
    logic [31:0] i;
    i = enc_b(32'h20, 3'b000);
    goto_pc(32'h10);
    present(32'h10, i);
    #1;
    chk("br_no_emit", bus.ins_out_valid, 1'b0);
    chk("br_ask", bus.ask_predictor, 1'b1);
    chk("br_now", bus.now_ins_addr, 32'h10);
    chk("br_jaddr", bus.jump_addr_to_predictor, 32'h30);
    chk("br_naddr", bus.next_addr_to_predictor, 32'h14);
    tick();
    chk("br_ask_once", bus.ask_predictor, 1'b0);
    bus.predictor_sgn_rdy = 1'b1; bus.jump = j;
    tick();
    bus.predictor_sgn_rdy = 1'b0;
    chk("br_emit", bus.ins_out_valid, 1'b1);
    chk("br_emit_ins", bus.ins_out, i);
    chk("br_emit_addr", bus.ins_out_addr, 32'h10);
    chk("br_pred_jump", bus.ins_out_pred_jump, j);
    chk("br_pc", bus.pc, exp_pc);
    $display("seq beq jump=%0d pc=%h", j, bus.pc);
  endtask

  task automatic model_emit(input logic [31:0] i, input logic [31:0] a, input bit pj);
    m_out_valid = 1'b1; m_out_ins = i; m_out_addr = a; m_out_pj = pj;
  endtask

  task automatic model_step();
    if (!bus.rdy) return;
    m_out_valid = 1'b0;
    if (bus.if_flush) begin
      m_pc = bus.addr_from_predictor;
      m_br_pending = 0; m_br_asked = 0; m_jalr = 0; m_hold = 1;
    end else if (m_hold) begin
      m_hold = 0;
    end else if (m_jalr) begin
      if (bus.jalr_resolve_valid) begin
        m_pc = bus.jalr_target;
        m_jalr = 0;
      end
    end else if (m_br_pending) begin
      if (!m_br_asked) begin
        m_br_asked = !bus.predictor_full;
      end else if (bus.predictor_sgn_rdy) begin
        model_emit(m_br_ins, m_br_addr, bus.jump);
        m_pc = bus.jump ? m_br_addr + 32'(m_br_off) : m_br_addr + 32'd4;
        m_br_pending = 0; m_br_asked = 0;
      end
    end else if (bus.ins_valid && bus.ins_addr == m_pc && !bus.dispatch_full) begin
      if (r_kind >= 7) begin
        m_br_pending = 1; m_br_addr = m_pc; m_br_ins = bus.ins; m_br_off = r_off;
      end else begin
        model_emit(bus.ins, m_pc, 1'b0);
        if (r_kind == 5) m_pc = m_pc + 32'(r_off);
        else if (r_kind == 6) m_jalr = 1;
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int asks;
    logic [31:0] tmp;
    bit exp_ask;

    vecs[0] = mk("add_at_0",      32'h0,        32'h0,        enc_add(),    1'b0, 1'b1, 1'b1, 32'h4);
    vecs[1] = mk("addi_wrap",     32'hFFFFFFFC, 32'hFFFFFFFC, enc_addi(),   1'b0, 1'b1, 1'b1, 32'h0);
    vecs[2] = mk("jal_minus8",    32'h8,        32'h8,        enc_j(-8),    1'b0, 1'b1, 1'b1, 32'h0);
    vecs[3] = mk("jal_wrap",      32'hFFFFFFF0, 32'hFFFFFFF0, enc_j(32'h20), 1'b0, 1'b1, 1'b1, 32'h10);
    vecs[4] = mk("jal_plus800",   32'h1000,     32'h1000,     enc_j(32'h800), 1'b0, 1'b1, 1'b1, 32'h1800);
    vecs[5] = mk("jalr_stall",    32'h20,       32'h20,       enc_jalr(),   1'b0, 1'b1, 1'b0, 32'h20);
    vecs[6] = mk("addr_mismatch", 32'h50,       32'h54,       enc_add(),    1'b0, 1'b0, 1'b1, 32'h50);
    vecs[7] = mk("dispatch_full", 32'h60,       32'h60,       enc_add(),    1'b1, 1'b0, 1'b1, 32'h60);

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_pc_valid", bus.pc_valid, 1'b0);
    chk("rst_ask", bus.ask_predictor, 1'b0);
    chk("rst_out_valid", bus.ins_out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_pc_valid", bus.pc_valid, 1'b1);
    chk("idle_pc", bus.pc, 32'h0);
    $display("seq reset pc=%h", bus.pc);

    foreach (vecs[k]) begin
      goto_pc(vecs[k].start_pc);
      bus.dispatch_full = vecs[k].dfull;
      present(vecs[k].ins_addr, vecs[k].ins);
      bus.dispatch_full = 1'b0;
      chk({vecs[k].name, "_valid"}, bus.ins_out_valid, vecs[k].exp_valid);
      if (vecs[k].exp_valid) begin
        chk({vecs[k].name, "_ins"}, bus.ins_out, vecs[k].ins);
        chk({vecs[k].name, "_addr"}, bus.ins_out_addr, vecs[k].start_pc);
        chk({vecs[k].name, "_pj"}, bus.ins_out_pred_jump, 1'b0);
      end
      chk({vecs[k].name, "_pc"}, bus.pc, vecs[k].exp_pc);
      chk({vecs[k].name, "_pc_valid"}, bus.pc_valid, vecs[k].exp_pc_valid);
      tick();
      chk({vecs[k].name, "_pulse"}, bus.ins_out_valid, 1'b0);
      $display("vec %s start=%h pc=%h", vecs[k].name, vecs[k].start_pc, bus.pc);
    end

    branch_seq(1'b1, 32'h30);
    branch_seq(1'b0, 32'h14);

    // predictor full for three cycles holds the query back
    goto_pc(32'h40);
    bus.predictor_full = 1'b1;
    present(32'h40, enc_b(32'h10, 3'b001));
    asks = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      asks += int'(bus.ask_predictor);
      tick();
    end
    chk("full_no_ask", asks, 0);
    bus.predictor_full = 1'b0;
    #1;
    chk("ask_4th_cycle", bus.ask_predictor, 1'b1);
    tick();
    asks = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      asks += int'(bus.ask_predictor);
      tick();
    end
    chk("ask_single_pulse", asks, 0);
    bus.predictor_sgn_rdy = 1'b1; bus.jump = 1'b0;
    tick();
    bus.predictor_sgn_rdy = 1'b0;
    chk("bne_emit_addr", bus.ins_out_addr, 32'h40);
    chk("bne_pc", bus.pc, 32'h44);
    $display("seq bne_full pc=%h", bus.pc);

    // flush coincident with the predictor answer
    goto_pc(32'h80);
    present(32'h80, enc_b(32'h20, 3'b000));
    tick();
    bus.if_flush = 1'b1; bus.addr_from_predictor = 32'h100;
    bus.predictor_sgn_rdy = 1'b1; bus.jump = 1'b1;
    tick();
    bus.if_flush = 1'b0; bus.predictor_sgn_rdy = 1'b0;
    #1;
    chk("flushwait_no_emit", bus.ins_out_valid, 1'b0);
    chk("flushwait_pc", bus.pc, 32'h100);
    chk("flushwait_hold_pv", bus.pc_valid, 1'b0);
    chk("flushwait_hold_ask", bus.ask_predictor, 1'b0);
    tick();
    chk("flushwait_idle_pv", bus.pc_valid, 1'b1);
    present(32'h100, enc_add());
    chk("flushwait_fetch_addr", bus.ins_out_addr, 32'h100);
    chk("flushwait_fetch_pc", bus.pc, 32'h104);
    $display("seq flush_in_wait pc=%h", bus.pc);

    // flush while a query would be raised
    goto_pc(32'h90);
    present(32'h90, enc_b(32'h20, 3'b000));
    bus.if_flush = 1'b1; bus.addr_from_predictor = 32'h200;
    #1;
    chk("flushask_ask", bus.ask_predictor, 1'b0);
    tick();
    bus.if_flush = 1'b0;
    chk("flushask_pc", bus.pc, 32'h200);
    $display("seq flush_in_ask pc=%h", bus.pc);

    // JALR stall until the ROB resolves the target
    goto_pc(32'h20);
    present(32'h20, enc_jalr());
    chk("jalr_emit", bus.ins_out_valid, 1'b1);
    chk("jalr_emit_addr", bus.ins_out_addr, 32'h20);
    bus.ins_valid = 1'b1; bus.ins_addr = 32'h20; bus.ins = enc_add();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("jalr_stall_pv", bus.pc_valid, 1'b0);
      chk("jalr_stall_emit", bus.ins_out_valid, 1'b0);
    end
    bus.ins_valid = 1'b0;
    bus.jalr_resolve_valid = 1'b1; bus.jalr_target = 32'h200;
    tick();
    chk("jalr_pc", bus.pc, 32'h200);
    chk("jalr_pc_valid", bus.pc_valid, 1'b1);
    bus.jalr_target = 32'h300;
    tick();
    bus.jalr_resolve_valid = 1'b0;
    chk("jalr_ignored_idle", bus.pc, 32'h200);
    $display("seq jalr pc=%h", bus.pc);

    // asynchronous reset between edges while waiting for the predictor
    goto_pc(32'hC0);
    present(32'hC0, enc_b(32'h40, 3'b000));
    tick();
    #1;
    chk("prerst_now", bus.now_ins_addr, 32'hC0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", bus.pc, 32'h0);
    chk("arst_out_addr", bus.ins_out_addr, 32'h0);
    chk("arst_now", bus.now_ins_addr, 32'h0);
    chk("arst_pc_valid", bus.pc_valid, 1'b0);
    chk("arst_out_valid", bus.ins_out_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.predictor_sgn_rdy = 1'b1; bus.jump = 1'b1;
    tick();
    bus.predictor_sgn_rdy = 1'b0;
    chk("stale_sgn_no_emit", bus.ins_out_valid, 1'b0);
    chk("stale_sgn_pc", bus.pc, 32'h0);
    chk("stale_sgn_pv", bus.pc_valid, 1'b1);
    $display("seq async_reset pc=%h", bus.pc);

    // randomized traffic against the reference model
    clear_inputs();
    m_pc = 32'h0; m_br_pending = 0; m_br_asked = 0; m_jalr = 0; m_hold = 0;
    m_out_valid = 0; m_out_pj = 0; m_out_ins = '0; m_out_addr = '0;
    m_br_addr = '0; m_br_ins = '0; m_br_off = 0;
    for (int c = 0; c < 3000; c++) begin
      r_kind = int'($urandom_range(0, 9));
      tmp = $urandom;
      r_off = 0;
      if (r_kind == 5) begin
        r_off = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        bus.ins = enc_j(r_off);
      end else if (r_kind == 6) begin
        bus.ins = enc_jalr();
      end else if (r_kind >= 7) begin
        r_off = (int'($urandom_range(0, 4095)) - 2048) * 2;
        bus.ins = enc_b(r_off, tmp[14:12]);
      end else begin
        bus.ins = {tmp[31:7], 7'b0110011};
      end
      bus.ins_valid          = ($urandom_range(0, 3) != 0);
      bus.ins_addr           = ($urandom_range(0, 9) == 0) ? m_pc + 32'd4 : m_pc;
      bus.dispatch_full      = ($urandom_range(0, 4) == 0);
      bus.rdy                = ($urandom_range(0, 9) != 0);
      bus.predictor_full     = ($urandom_range(0, 2) == 0);
      bus.predictor_sgn_rdy  = ($urandom_range(0, 2) == 0);
      bus.jump               = ($urandom_range(0, 1) != 0);
      bus.if_flush           = ($urandom_range(0, 24) == 0);
      tmp = $urandom;
      bus.addr_from_predictor = tmp & 32'hFFFF_FFFC;
      bus.jalr_resolve_valid = ($urandom_range(0, 2) == 0);
      tmp = $urandom;
      bus.jalr_target = tmp & 32'hFFFF_FFFC;
      #1;
      exp_ask = m_br_pending && !m_br_asked && bus.rdy && !bus.predictor_full && !bus.if_flush;
      chk("rnd_pc", bus.pc, m_pc);
      chk("rnd_pc_valid", bus.pc_valid, !(m_br_pending || m_jalr || m_hold));
      chk("rnd_ask", bus.ask_predictor, exp_ask);
      if (exp_ask) begin
        chk("rnd_now", bus.now_ins_addr, m_br_addr);
        chk("rnd_jaddr", bus.jump_addr_to_predictor, m_br_addr + 32'(m_br_off));
        chk("rnd_naddr", bus.next_addr_to_predictor, m_br_addr + 32'd4);
      end
      model_step();
      tick();
      chk("rnd_out_valid", bus.ins_out_valid, m_out_valid);
      if (m_out_valid) begin
        chk("rnd_out_ins", bus.ins_out, m_out_ins);
        chk("rnd_out_addr", bus.ins_out_addr, m_out_addr);
        chk("rnd_out_pj", bus.ins_out_pred_jump, m_out_pj);
      end
    end
    $display("seq random cycles=3000 pc=%h", bus.pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
